// File: rtl/enc8_3_pkg.sv
// Shared widths, state encoding and helpers for the enc8_3 request encoder.
package enc8_3_pkg;

    localparam int unsigned REQ_W  = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic {IDLE, BUSY} state_e;

    // One-hot mask for a binary code.
    function automatic logic [REQ_W-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [REQ_W-1:0] mask;
        mask       = '0;
        mask[code] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/enc8_3_prio.sv
// Combinational request selector for enc8_3_pend; holds no state.
// Build option ENC8_3_ROUND_ROBIN_EN: scan upward from start (start, start+1, ... mod 8).
// Default build: scan downward from start-1 (start tied to 0 gives highest index first).
module enc8_3_prio
    import enc8_3_pkg::*;
(
    input  logic [REQ_W-1:0]  cand,
    input  logic [CODE_W-1:0] start,
    output logic [CODE_W-1:0] code,
    output logic              any
);

    logic [CODE_W-1:0] idx;

    // First set candidate in scan order wins.
    always_comb begin
        code = '0;
        any  = 1'b0;
        idx  = '0;
        for (int i = 0; i < REQ_W; i++) begin
`ifdef ENC8_3_ROUND_ROBIN_EN
            idx = start + CODE_W'(i);
`else
            idx = start - CODE_W'(1) - CODE_W'(i);
`endif
            if (!any && cand[idx]) begin
                any  = 1'b1;
                code = idx;
            end
        end
    end

endmodule

// File: rtl/enc8_3_pend.sv
// 8-to-3 encoder with pending-request capture and a valid/ready output handshake.
// Build option ENC8_3_ROUND_ROBIN_EN: round-robin selection with a last-served pointer;
// default build uses fixed highest-index priority and has no pointer register.
module enc8_3_pend
    import enc8_3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REQ_W-1:0]  X,
    input  logic              ready,
    input  logic              ovf_clr,
    output logic [CODE_W-1:0] Y,
    output logic              valid,
    output logic [REQ_W-1:0]  pend,
    output logic              ovf
);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] y_q, y_d;
    logic [REQ_W-1:0]  pend_q, pend_d;
    logic              ovf_q, ovf_d;

    logic              busy;
    logic              load;
    logic              dup;
    logic [REQ_W-1:0]  cand;
    logic [CODE_W-1:0] start;
    logic [CODE_W-1:0] sel_code;
    logic              sel_any;

`ifdef ENC8_3_ROUND_ROBIN_EN
    logic [CODE_W-1:0] last_q, last_d;
    assign start = last_q + CODE_W'(1);
`else
    assign start = '0;
`endif

    enc8_3_prio u_prio (
        .cand  (cand),
        .start (start),
        .code  (sel_code),
        .any   (sel_any)
    );

    // Next-state: load a new code on handshake or idle, otherwise accumulate requests.
    always_comb begin
        busy    = (state_q == BUSY);
        load    = !busy || ready;
        cand    = pend_q | X;
        // Re-request of something already pending, or of the stalled presented code.
        dup     = (|(X & pend_q)) || (busy && !ready && X[y_q]);
        state_d = state_q;
        y_d     = y_q;
        pend_d  = pend_q;
`ifdef ENC8_3_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        if (load) begin
            if (sel_any) begin
                state_d = BUSY;
                y_d     = sel_code;
                pend_d  = cand & ~onehot(sel_code);
`ifdef ENC8_3_ROUND_ROBIN_EN
                last_d  = sel_code;
`endif
            end else begin
                state_d = IDLE;
                pend_d  = '0;
            end
        end else begin
            // Presented code stays out of pend; a repeat of it is merged.
            pend_d = (pend_q | X) & ~onehot(y_q);
        end
        if (dup) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
`ifdef ENC8_3_ROUND_ROBIN_EN
            last_q  <= CODE_W'(7);
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
`ifdef ENC8_3_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign Y     = y_q;
    assign valid = (state_q == BUSY);
    assign pend  = pend_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_enc8_3_pend.sv
// Directed self-checking bench for enc8_3_pend (fixed or round-robin build).
module tb_enc8_3_pend;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x;
    logic       ready;
    logic       ovf_clr;
    logic [2:0] y;
    logic       valid;
    logic [7:0] pend;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enc8_3_pend dut (
        .clk     (clk),
        .rst     (rst),
        .X       (x),
        .ready   (ready),
        .ovf_clr (ovf_clr),
        .Y       (y),
        .valid   (valid),
        .pend    (pend),
        .ovf     (ovf)
    );

    // Advance one edge; outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; x = 8'h00; ready = 1'b0; ovf_clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; x = 8'hFF; ready = 1'b1; ovf_clr = 1'b0;
        step();
        checks++;
        if ({valid, y, pend, ovf} !== 13'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b y=%0d pend=%h ovf=%b want all zero",
                     valid, y, pend, ovf);
        end
        rst = 1'b0; x = 8'h00;
        step();
        checks++;
        if (valid !== 1'b0 || pend !== 8'h00) begin
            errors++;
            $display("FAIL ready_idle: valid=%b pend=%h want 0/00", valid, pend);
        end
    endtask

    task automatic test_single();
        do_reset();
        x = 8'h20; ready = 1'b1;
        step();
        x = 8'h00;
        checks++;
        if (valid !== 1'b1 || y !== 3'd5 || pend !== 8'h00) begin
            errors++;
            $display("FAIL single_load: valid=%b y=%0d pend=%h want 1/5/00", valid, y, pend);
        end
        step();
        checks++;
        if (valid !== 1'b0 || pend !== 8'h00 || y !== 3'd5) begin
            errors++;
            $display("FAIL single_drain: valid=%b y=%0d pend=%h want 0/5/00", valid, y, pend);
        end
    endtask

    task automatic test_stall();
        logic [2:0] first_y;
        logic [2:0] second_y;
        logic [7:0] first_pend;
`ifdef ENC8_3_ROUND_ROBIN_EN
        first_y = 3'd0; second_y = 3'd7; first_pend = 8'h80;
`else
        first_y = 3'd7; second_y = 3'd0; first_pend = 8'h01;
`endif
        do_reset();
        x = 8'h81; ready = 1'b0;
        step();
        x = 8'h00;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid !== 1'b1 || y !== first_y || pend !== first_pend) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b y=%0d pend=%h want 1/%0d/%h",
                         i, valid, y, pend, first_y, first_pend);
            end
            if (i < 2) step();
        end
        ready = 1'b1;
        step();
        checks++;
        if (valid !== 1'b1 || y !== second_y || pend !== 8'h00) begin
            errors++;
            $display("FAIL back_to_back: valid=%b y=%0d pend=%h want 1/%0d/00",
                     valid, y, pend, second_y);
        end
        step();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: valid=%b want 0", valid);
        end
    endtask

    task automatic test_ovf();
        do_reset();
        x = 8'h08; ready = 1'b0;
        step();
        checks++;
        if (valid !== 1'b1 || y !== 3'd3 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_setup: valid=%b y=%0d ovf=%b want 1/3/0", valid, y, ovf);
        end
        step();
        checks++;
        if (ovf !== 1'b1 || pend !== 8'h00 || y !== 3'd3) begin
            errors++;
            $display("FAIL ovf_presented_dup: ovf=%b pend=%h y=%0d want 1/00/3", ovf, pend, y);
        end
        x = 8'h00; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b want 0", ovf);
        end
        x = 8'h02;
        step();
        checks++;
        if (pend !== 8'h02 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pend_new: pend=%h ovf=%b want 02/0", pend, ovf);
        end
        ovf_clr = 1'b1;
        step();
        x = 8'h00; ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1 || pend !== 8'h02) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf=%b pend=%h want 1/02", ovf, pend);
        end
    endtask

    task automatic test_rerequest();
        do_reset();
        x = 8'h04; ready = 1'b0;
        step();
        ready = 1'b1;
        step();
        x = 8'h00;
        checks++;
        if (valid !== 1'b1 || y !== 3'd2 || ovf !== 1'b0 || pend !== 8'h00) begin
            errors++;
            $display("FAIL rerequest: valid=%b y=%0d ovf=%b pend=%h want 1/2/0/00",
                     valid, y, ovf, pend);
        end
        step();
        checks++;
        if (valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rerequest_drain: valid=%b ovf=%b want 0/0", valid, ovf);
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        x = 8'h10; ready = 1'b0;
        step();
        x = 8'h0F;
        step();
        x = 8'h00;
        checks++;
        if (valid !== 1'b1 || y !== 3'd4 || pend !== 8'h0F) begin
            errors++;
            $display("FAIL busy_setup: valid=%b y=%0d pend=%h want 1/4/0F", valid, y, pend);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (valid !== 1'b0 || y !== 3'd0 || pend !== 8'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: valid=%b y=%0d pend=%h ovf=%b want 0/0/00/0",
                     valid, y, pend, ovf);
        end
    endtask

    task automatic test_sequence();
        logic [2:0] exp_y;
        do_reset();
        x = 8'hFF; ready = 1'b1;
        step();
        x = 8'h00;
        for (int i = 0; i < 8; i++) begin
`ifdef ENC8_3_ROUND_ROBIN_EN
            exp_y = 3'(i);
`else
            exp_y = 3'(7 - i);
`endif
            checks++;
            if (valid !== 1'b1 || y !== exp_y) begin
                errors++;
                $display("FAIL seq[%0d]: valid=%b y=%0d want 1/%0d", i, valid, y, exp_y);
            end
            step();
        end
        checks++;
        if (valid !== 1'b0 || pend !== 8'h00) begin
            errors++;
            $display("FAIL seq_end: valid=%b pend=%h want 0/00", valid, pend);
        end
    endtask

    initial begin
        rst = 1'b1; x = 8'h00; ready = 1'b0; ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_ovf();
        test_rerequest();
        test_reset_busy();
        test_sequence();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc8_3_pend.md
ENC8_3_PEND -- requirements
Module: enc8_3_pend

Interface
REQ-001 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 Port rst, input, 1, reset; synchronous, active-high.
REQ-003 Port X, input, 8, request pulses; bit k high for one or more cycles requests code k.
REQ-004 Port ready, input, 1, consumer accepts the presented code when ready and valid are both high.
REQ-005 Port ovf_clr, input, 1, single-cycle clear of ovf.
REQ-006 Port Y, output, 3, registered binary code of the presented request.
REQ-007 Port valid, output, 1, registered; Y holds a presented request.
REQ-008 Port pend, output, 8, registered pending-request vector, excluding the presented code.
REQ-009 Port ovf, output, 1, registered sticky flag for a merged duplicate request.

Function
REQ-010 Two states: IDLE (valid=0), BUSY (valid=1); state equals valid.
REQ-011 Load condition: load = !valid || (valid && ready).
REQ-012 Candidates: cand = pend | X, evaluated combinationally every cycle.
REQ-013 On load with cand != 0: Y <= sel(cand), valid <= 1, pend <= cand & ~onehot(sel(cand)).
REQ-014 On load with cand == 0: valid <= 0, Y holds its last value, pend <= 0.
REQ-015 When not loading (BUSY, ready=0): Y and valid hold; pend <= pend | X.
REQ-016 Latency: X bit set in cycle n while IDLE and pend==0 -> valid=1 with Y=k from edge n onward.
REQ-017 Back-to-back: handshake in cycle n with cand != 0 -> new Y after edge n, valid stays 1, no bubble.
REQ-018 Y shall not change while valid=1 and ready=0.
REQ-019 Duplicate: X[k] high while pend[k]=1, or while valid=1, Y=k and no handshake that cycle -> ovf <= 1, request merged (not counted twice).
REQ-020 X[k] high in the same cycle the presented Y=k handshakes -> new request for k, entered into cand, no ovf.
REQ-021 ovf_clr and a new duplicate in the same cycle -> ovf <= 1 (set wins).
REQ-022 Fixed priority (default): sel() returns the highest set index.
REQ-023 ready while IDLE has no effect.

Reset
REQ-024 rst high at an edge: valid=0, Y=0, pend=0, ovf=0, state IDLE, RR pointer=7; X that cycle discarded.
REQ-025 rst mid-BUSY drops the presented code and all pending requests without handshake.

Configuration
REQ-026 Macro ENC8_3_ROUND_ROBIN_EN defined: sel() scans indices last+1, last+2, ... mod 8 and returns the first set bit; last <= sel() on every load with cand != 0.
REQ-027 Macro undefined: fixed priority per REQ-022; no pointer register exists.

Structure
REQ-028 Package enc8_3_pkg holds REQ_W=8, CODE_W=3, and the state enum {IDLE, BUSY}.
REQ-029 Sub-module enc8_3_prio: combinational selector, inputs cand[7:0] and start[2:0], outputs code[2:0] and any. Start is tied to 0 with highest-first search in fixed mode.
REQ-030 enc8_3_pend holds all registers; enc8_3_prio holds none.

Verification
REQ-031 Reset, then X=8'h20 for one cycle, ready=1 -> Y=5, valid=1 for one cycle, then valid=0, pend=0.
REQ-032 X=8'h81 for one cycle, ready=0 for 3 cycles then 1 -> Y=7 held while stalled, pend=8'h01; after the handshake Y=0 with no bubble; then valid=0.
REQ-033 While Y=3 is stalled, pulse X=8'h08 -> ovf=1, pend unchanged; pulse ovf_clr -> ovf=0.
REQ-034 Handshake of Y=2 with X=8'h04 in the same cycle -> Y=2 is presented again next, ovf=0.
REQ-035 rst asserted while valid=1 and pend=8'h0F -> next cycle valid=0, pend=0, Y=0.
REQ-036 With ENC8_3_ROUND_ROBIN_EN defined, X=8'hFF for one cycle, ready=1 -> Y sequence 0,1,2,...,7. Without the macro, the sequence is 7,6,...,0.
